// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package riscv_muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [2:0] {
        MUL_NONE   = 3'b000,
        MUL_MUL    = 3'b001,
        MUL_MULH   = 3'b010,
        MUL_MULHSU = 3'b011,
        MUL_MULHU  = 3'b100
    } mulsel_t;

    typedef enum logic [2:0] {
        DIV_NONE = 3'b000,
        DIV_DIV  = 3'b001,
        DIV_DIVU = 3'b010,
        DIV_REM  = 3'b011,
        DIV_REMU = 3'b100
    } divsel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Decoder/hazard-side bundle of the multiply/divide unit: start strobes, operands, status, result.
interface muldiv_unit_if
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) ();
    logic            start_mul;
    logic            start_div;
    logic [2:0]      mulsel;
    logic [2:0]      divsel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_mul, start_div, mulsel, divsel, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start_mul, start_div, mulsel, divsel, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes going in, negate/half-select coming out.
module muldiv_sign_fix
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic              is_mul_i,
    input  logic [2:0]        sel_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   a_mag_o,
    output logic [XLEN-1:0]   b_mag_o,
    input  logic [2*XLEN-1:0] prod_i,
    input  logic [XLEN-1:0]   quo_i,
    input  logic [XLEN-1:0]   rem_i,
    input  logic              div0_i,
    output logic [XLEN-1:0]   res_o
);
    logic              a_signed, b_signed, a_neg, b_neg, is_rem;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (is_mul_i) begin
            a_signed = (sel_i == MUL_MUL) || (sel_i == MUL_MULH) || (sel_i == MUL_MULHSU);
            b_signed = (sel_i == MUL_MUL) || (sel_i == MUL_MULH);
        end else begin
            a_signed = (sel_i == DIV_DIV) || (sel_i == DIV_REM);
            b_signed = a_signed;
        end
    end

    assign a_neg   = a_signed & a_i[XLEN-1];
    assign b_neg   = b_signed & b_i[XLEN-1];
    assign a_mag_o = a_neg ? -a_i : a_i;
    assign b_mag_o = b_neg ? -b_i : b_i;

    // Remainder follows the dividend's sign; quotient/product follow sign(a)^sign(b).
    assign prod_s = (a_neg ^ b_neg) ? -prod_i : prod_i;
    assign quo_s  = (a_neg ^ b_neg) ? -quo_i : quo_i;
    assign rem_s  = a_neg ? -rem_i : rem_i;
    assign is_rem = (sel_i == DIV_REM) || (sel_i == DIV_REMU);

    always_comb begin
        res_o = '0;
        if (is_mul_i) begin
            res_o = (sel_i == MUL_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (div0_i) begin
            res_o = is_rem ? a_i : '1;
        end else begin
            res_o = is_rem ? rem_s : quo_s;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// sharing one accumulator; busy stalls the front of the pipeline while an op is in flight.
module muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic         clk,
    input  logic         Rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN + 1;

    md_state_t       state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q;
    logic            is_mul_q, div0_q, done_q;
    logic [2:0]      sel_q;
    logic [XLEN-1:0] a_q, b_q, result_q;

    logic            mul_ok, div_ok, accept, load_res;
    logic            fx_is_mul;
    logic [2:0]      op_sel, fx_sel;
    logic [XLEN-1:0] fx_a, fx_b, a_mag, b_mag, fix_res;
    logic [XLEN:0]   mul_sum, div_rs, div_diff;
    logic [AW-1:0]   mul_next, div_next;

    assign mul_ok = bus.start_mul && (bus.mulsel != 3'b000);
    assign div_ok = bus.start_div && (bus.divsel != 3'b000);
    assign accept = (state_q == IDLE) && !bus.flush && (mul_ok || div_ok);
    assign op_sel = mul_ok ? bus.mulsel : bus.divsel;

    // While idle the sign unit looks at the incoming operands so magnitudes can seed the accumulator.
    assign fx_is_mul = (state_q == IDLE) ? mul_ok : is_mul_q;
    assign fx_sel    = (state_q == IDLE) ? op_sel : sel_q;
    assign fx_a      = (state_q == IDLE) ? bus.a  : a_q;
    assign fx_b      = (state_q == IDLE) ? bus.b  : b_q;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .is_mul_i (fx_is_mul),
        .sel_i    (fx_sel),
        .a_i      (fx_a),
        .b_i      (fx_b),
        .a_mag_o  (a_mag),
        .b_mag_o  (b_mag),
        .prod_i   (acc_q[2*XLEN-1:0]),
        .quo_i    (acc_q[XLEN-1:0]),
        .rem_i    (acc_q[2*XLEN-1:XLEN]),
        .div0_i   (div0_q),
        .res_o    (fix_res)
    );

    // Multiply: {hi, multiplier} shifts right, adding the multiplicand when the lsb is set.
    assign mul_sum  = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, a_mag} : '0);
    assign mul_next = {1'b0, mul_sum, acc_q[XLEN-1:1]};

    // Divide: {rem, quotient} shifts left; a non-negative trial difference sets the quotient bit.
    assign div_rs   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_rs - {1'b0, b_mag};
    assign div_next = {div_diff[XLEN] ? div_rs : div_diff, acc_q[XLEN-2:0], ~div_diff[XLEN]};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        load_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (!mul_ok && (bus.b == '0)) ? FIX : CALC;
                    acc_d   = mul_ok ? {{(XLEN+1){1'b0}}, b_mag} : {{(XLEN+1){1'b0}}, a_mag};
                end
            end
            CALC: begin
                acc_d = is_mul_q ? mul_next : div_next;
                if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
            end
            FIX: begin
                state_d  = DONE;
                load_res = !bus.flush;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            done_q  <= load_res;
            if (accept) begin
                is_mul_q <= mul_ok;
                sel_q    <= op_sel;
                a_q      <= bus.a;
                b_q      <= bus.b;
                div0_q   <= !mul_ok && (bus.b == '0);
                cnt_q    <= '0;
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (load_res) result_q <= fix_res;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic Rst;
    int   total = 0;
    int   bad   = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with plain 64-bit and 32-bit arithmetic.
    function automatic logic [31:0] model(input bit is_mul, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, p;
        logic [31:0] r;
        r = '0;
        if (is_mul) begin
            pa = (sel == 3'd4) ? longint'({32'b0, a}) : longint'(signed'(a));
            pb = (sel == 3'd1 || sel == 3'd2) ? longint'(signed'(b)) : longint'({32'b0, b});
            p  = pa * pb;
            r  = (sel == 3'd1) ? p[31:0] : p[63:32];
        end else if (b == 32'd0) begin
            r = (sel == 3'd1 || sel == 3'd2) ? 32'hFFFF_FFFF : a;
        end else begin
            case (sel)
                3'd1: r = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(signed'(a) / signed'(b));
                3'd2: r = a / b;
                3'd3: r = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(signed'(a) % signed'(b));
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge just after the DONE cycle.
    task automatic run_op(input string tag, input bit is_mul, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b, input bit both, input bit poke);
        logic [31:0] exp_res;
        int          exp_lat, lat;
        bit          busy_ok;
        exp_res       = model(is_mul, sel, a, b);
        exp_lat       = (!is_mul && b == 32'd0) ? 2 : XLEN + 2;
        bus.start_mul = is_mul || both;
        bus.start_div = !is_mul || both;
        bus.mulsel    = is_mul ? sel : 3'($urandom_range(0, 4));
        bus.divsel    = is_mul ? 3'($urandom_range(1, 4)) : sel;
        bus.a         = a;
        bus.b         = b;
        lat           = 0;
        busy_ok       = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (n == 1) begin
                bus.start_mul = poke;
                bus.start_div = 1'b0;
                bus.mulsel    = 3'($urandom_range(1, 4));
                bus.a         = $urandom;
                bus.b         = $urandom;
            end else begin
                bus.start_mul = 1'b0;
            end
        end
        bus.start_mul = 1'b0;
        bus.start_div = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_flush();
        logic [31:0] prev;
        bit          saw_done;
        prev          = bus.result;
        bus.start_div = 1'b1;
        bus.divsel    = 3'd1;
        bus.a         = $urandom;
        bus.b         = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            bus.start_div = 1'b0;
        end
        check("flush_busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy_after", 64'(bus.busy), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check("flush_no_done", 64'(saw_done), 64'd0);
        check("flush_result_kept", 64'(bus.result), 64'(prev));

        bus.start_mul = 1'b1;
        bus.mulsel    = 3'd1;
        bus.flush     = 1'b1;
        @(negedge clk);
        bus.start_mul = 1'b0;
        bus.flush     = 1'b0;
        check("flush_with_start", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [31:0] prev;
        bit          m;
        Rst           = 1'b1;
        bus.start_mul = 1'b0;
        bus.start_div = 1'b0;
        bus.mulsel    = '0;
        bus.divsel    = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        Rst = 1'b0;
        @(negedge clk);

        run_op("mul_7_m3",     1, 3'd1, 32'd7,          32'hFFFF_FFFD, 0, 0);
        run_op("mulh_min",     1, 3'd2, 32'h8000_0000,  32'h8000_0000, 0, 0);
        run_op("mulhu_min",    1, 3'd4, 32'h8000_0000,  32'h8000_0000, 0, 0);
        run_op("mulhsu_m1",    1, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0);
        run_op("div_m7_2",     0, 3'd1, 32'hFFFF_FFF9,  32'd2,         0, 0);
        run_op("rem_m7_2",     0, 3'd3, 32'hFFFF_FFF9,  32'd2,         0, 0);
        run_op("divu_big",     0, 3'd2, 32'hFFFF_FFFF,  32'h10,        0, 0);
        run_op("remu_big",     0, 3'd4, 32'hFFFF_FFFF,  32'h10,        0, 0);
        run_op("div_by0",      0, 3'd1, 32'd5,          32'd0,         0, 0);
        run_op("rem_by0",      0, 3'd3, 32'd5,          32'd0,         0, 0);
        run_op("div_ovf",      0, 3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0);
        run_op("rem_ovf",      0, 3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0);
        run_op("both_start",   1, 3'd1, 32'd6,          32'd7,         1, 0);
        run_op("poke_busy",    0, 3'd2, 32'd100,        32'd7,         0, 1);

        prev          = bus.result;
        bus.start_mul = 1'b1;
        bus.mulsel    = 3'd0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        @(negedge clk);
        bus.start_mul = 1'b0;
        check("sel0_ignored", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("sel0_no_done", 64'(bus.done), 64'd0);
        check("sel0_result", 64'(bus.result), 64'(prev));

        run_flush();

        bus.start_mul = 1'b1;
        bus.mulsel    = 3'd1;
        bus.a         = 32'd3;
        bus.b         = 32'd5;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            bus.start_mul = 1'b0;
        end
        Rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 1, 3'd1, 32'd9, 32'd11, 0, 0);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            run_op(m ? "rnd_mul" : "rnd_div", m, 3'($urandom_range(1, 4)), pick(), pick(), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
